// File: rtl/gpio_event_monitor.sv
// Captures masked changes on a GPIO output bus with a cycle timestamp into a
// show-ahead FIFO, and flags a bus that has gone idle for too long.
module gpio_event_monitor #(
    parameter int WIDTH    = 34,
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16,
    parameter int TO_WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         gpio_in,
    input  logic [WIDTH-1:0]         mask,
    input  logic [TO_WIDTH-1:0]      timeout_limit,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [TS_WIDTH-1:0]      rd_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [TO_WIDTH-1:0] idle_q, idle_d;
    logic                en_d_q, en_d_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                timeout_q, timeout_d;

    logic [WIDTH-1:0]    mem_data_q [DEPTH];
    logic [WIDTH-1:0]    mem_data_d [DEPTH];
    logic [TS_WIDTH-1:0] mem_ts_q   [DEPTH];
    logic [TS_WIDTH-1:0] mem_ts_d   [DEPTH];

    logic enable_edge;
    logic active;
    logic event_hit;
    logic is_full;
    logic is_empty;
    logic pop;
    logic push;

    assign enable_edge = en & ~en_d_q;
    assign active      = en & en_d_q;
    assign event_hit   = active & (|((gpio_in ^ prev_q) & mask));
    assign is_full     = (count_q == CW'(DEPTH));
    assign is_empty    = (count_q == '0);

    // Read handshake: rd_valid means the head entry is presented on
    // rd_data/rd_ts; a pop happens on any edge where rd_en && rd_valid.
    // rd_en while empty is ignored. A push into a full FIFO is accepted only
    // when a pop frees the head slot on the same edge.
    assign pop  = rd_en & ~is_empty;
    assign push = event_hit & (~is_full | pop);

    always_comb begin
        prev_d     = prev_q;
        ts_d       = ts_q;
        idle_d     = idle_q;
        en_d_d     = en;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        mem_data_d = mem_data_q;
        mem_ts_d   = mem_ts_q;

        if (enable_edge) begin
            prev_d = gpio_in;
            ts_d   = '0;
            idle_d = '0;
        end else if (active) begin
            prev_d = gpio_in;
            if (ts_q != '1) begin
                ts_d = ts_q + TS_WIDTH'(1);
            end
            // Watchdog: idle stops counting once it reaches the limit.
            if (timeout_limit != '0) begin
                if (event_hit) begin
                    idle_d = '0;
                end else begin
                    if (idle_q < timeout_limit) begin
                        idle_d = idle_q + TO_WIDTH'(1);
                    end
                    if (idle_d >= timeout_limit) begin
                        timeout_d = 1'b1;
                    end
                end
            end
        end

        if (event_hit && is_full && !pop) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            mem_data_d[wr_ptr_q] = gpio_in;
            mem_ts_d[wr_ptr_q]   = ts_q;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Soft clear drops everything but re-arms prev on the live bus value.
        if (clear) begin
            prev_d     = gpio_in;
            ts_d       = '0;
            idle_d     = '0;
            en_d_d     = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            timeout_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            ts_q       <= '0;
            idle_q     <= '0;
            en_d_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            ts_q       <= ts_d;
            idle_q     <= idle_d;
            en_d_q     <= en_d_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    // Storage needs no reset: the head is only exposed while count is nonzero.
    always_ff @(posedge clk) begin
        mem_data_q <= mem_data_d;
        mem_ts_q   <= mem_ts_d;
    end

    assign rd_valid = ~is_empty;
    assign rd_data  = is_empty ? '0 : mem_data_q[rd_ptr_q];
    assign rd_ts    = is_empty ? '0 : mem_ts_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = is_full;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_gpio_event_monitor.sv
// Randomized and directed bench for gpio_event_monitor, checked every cycle
// against a queue-based behavioural model.
module tb_gpio_event_monitor;
  localparam int W   = 34;
  localparam int D   = 16;
  localparam int TSW = 6;
  localparam int TOW = 20;
  localparam int CW  = $clog2(D) + 1;
  localparam int TS_MAX = (1 << TSW) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           clear = 1'b0;
  logic [W-1:0]   gpio_in = '0;
  logic [W-1:0]   mask = '1;
  logic [TOW-1:0] timeout_limit = '0;
  logic           rd_en = 1'b0;
  logic           rd_valid;
  logic [W-1:0]   rd_data;
  logic [TSW-1:0] rd_ts;
  logic [CW-1:0]  count;
  logic           full;
  logic           overflow;
  logic           timeout;

  always #5 clk = ~clk;

  gpio_event_monitor #(.WIDTH(W), .DEPTH(D), .TS_WIDTH(TSW), .TO_WIDTH(TOW)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .gpio_in(gpio_in),
    .mask(mask), .timeout_limit(timeout_limit), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ts(rd_ts), .count(count),
    .full(full), .overflow(overflow), .timeout(timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [W-1:0]   data;
    logic [TSW-1:0] ts;
  } ent_t;

  ent_t         exp_q[$];
  logic [W-1:0] m_prev = '0;
  int           m_ts = 0;
  int           m_idle = 0;
  bit           m_en_d = 0;
  bit           m_ovf = 0;
  bit           m_to = 0;
  bit           m_live = 0;
  int           m_n;
  bit           m_pop;
  bit           m_ev;
  ent_t         m_ent;

  always @(posedge clk) begin
    if (rst || clear) begin
      exp_q.delete();
      m_prev = rst ? '0 : gpio_in;
      m_ts = 0;
      m_idle = 0;
      m_en_d = 0;
      m_ovf = 0;
      m_to = 0;
      if (rst) m_live = 1;
    end else begin
      m_n = exp_q.size();
      m_pop = rd_en && (m_n > 0);
      m_ev = 0;
      if (en && !m_en_d) begin
        m_prev = gpio_in;
        m_ts = 0;
        m_idle = 0;
      end else if (en) begin
        m_ev = ((gpio_in ^ m_prev) & mask) != '0;
        m_ent.data = gpio_in;
        m_ent.ts = TSW'(m_ts);
        m_prev = gpio_in;
        m_ts = (m_ts < TS_MAX) ? m_ts + 1 : TS_MAX;
        if (timeout_limit != 0) begin
          if (m_ev) m_idle = 0;
          else begin
            if (m_idle < int'(timeout_limit)) m_idle++;
            if (m_idle >= int'(timeout_limit)) m_to = 1;
          end
        end
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_ev) begin
        if (m_n == D && !m_pop) m_ovf = 1;
        else exp_q.push_back(m_ent);
      end
      m_en_d = en;
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check("count", count, exp_q.size());
      check("rd_valid", rd_valid, exp_q.size() > 0);
      check("full", full, exp_q.size() == D);
      check("overflow", overflow, m_ovf);
      check("timeout", timeout, m_to);
      if (exp_q.size() > 0) begin
        check("rd_data", rd_data, exp_q[0].data);
        check("rd_ts", rd_ts, exp_q[0].ts);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [W-1:0] e1, e2, e3, first17;
  int rd_pct;

  initial begin
    cyc(2);
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_ts", rd_ts, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_to", timeout, 0);
    rst = 0;
    cyc();

    // Two changes: at the 3rd and 7th enabled cycles after the enable edge.
    en = 1;
    cyc();                    // enable edge
    cyc(2);                   // ts 0, 1
    gpio_in = 'h5;
    cyc();                    // ts 2 event
    check("t1_valid", rd_valid, 1);
    check("t1_data0", rd_data, 'h5);
    check("t1_ts0", rd_ts, 2);
    cyc(3);                   // ts 3..5
    gpio_in = 'h4;
    cyc();                    // ts 6 event
    check("t1_count", count, 2);
    rd_en = 1;
    cyc();
    check("t1_data1", rd_data, 'h4);
    check("t1_ts1", rd_ts, 6);
    cyc();
    rd_en = 0;
    check("t1_empty", count, 0);

    // Masked-off bit toggles are not logged.
    mask = 'h1;
    repeat (10) begin
      gpio_in = gpio_in ^ 'h2;
      cyc();
    end
    check("t2_none", count, 0);
    gpio_in = gpio_in ^ 'h1;
    cyc();
    check("t2_count", count, 1);
    check("t2_data", rd_data, gpio_in);
    rd_en = 1;
    cyc();
    rd_en = 0;

    // Overflow: 17 changes, no reads.
    mask = '1;
    first17 = gpio_in + 1;
    repeat (17) begin
      gpio_in = gpio_in + 1;
      cyc();
    end
    check("t3_full", full, 1);
    check("t3_count", count, 16);
    check("t3_ovf", overflow, 1);
    check("t3_head", rd_data, first17);
    rd_en = 1;
    gpio_in = gpio_in + 1;
    cyc();
    check("t3_pp_count", count, 16);
    check("t3_pp_ovf", overflow, 1);
    cyc(16);
    rd_en = 0;
    check("t3_drained", count, 0);

    // Watchdog fires exactly 100 cycles after the last event.
    timeout_limit = 100;
    gpio_in = gpio_in + 1;
    cyc();
    cyc(99);
    check("t4_to_early", timeout, 0);
    cyc();
    check("t4_to_fire", timeout, 1);
    rd_en = 1;
    cyc();
    rd_en = 0;
    clear = 1;
    cyc();
    clear = 0;
    timeout_limit = 0;
    check("t4_clr_to", timeout, 0);
    cyc(1000);
    check("t4_to_off", timeout, 0);
    gpio_in = gpio_in + 1;
    cyc();
    check("t4_ts_sat", rd_ts, TS_MAX);
    rd_en = 1;
    cyc();
    rd_en = 0;

    // Clear on an edge with a bus change discards everything.
    timeout_limit = 3;
    repeat (5) begin
      gpio_in = gpio_in + 1;
      cyc();
    end
    cyc(5);
    check("t5_count", count, 5);
    check("t5_to", timeout, 1);
    clear = 1;
    gpio_in = gpio_in + 1;
    cyc();
    clear = 0;
    timeout_limit = 0;
    check("t5_clr_count", count, 0);
    check("t5_clr_ovf", overflow, 0);
    check("t5_clr_to", timeout, 0);
    rd_en = 1;
    cyc();
    rd_en = 0;
    check("t5_rd_empty", count, 0);
    check("t5_rd_valid", rd_valid, 0);

    // en low freezes capture; re-enable restarts ts.
    gpio_in = gpio_in + 1;
    e1 = gpio_in;
    cyc();
    gpio_in = gpio_in + 1;
    e2 = gpio_in;
    cyc();
    en = 0;
    repeat (20) begin
      gpio_in = W'({$urandom(), $urandom()});
      cyc();
    end
    check("t6_frozen", count, 2);
    en = 1;
    cyc();
    gpio_in = gpio_in ^ 'h1;
    e3 = gpio_in;
    cyc();
    check("t6_count", count, 3);
    check("t6_d1", rd_data, e1);
    rd_en = 1;
    cyc();
    check("t6_d2", rd_data, e2);
    cyc();
    check("t6_d3", rd_data, e3);
    check("t6_ts3", rd_ts, 0);
    cyc();
    rd_en = 0;

    // Randomized traffic against the model.
    rd_pct = 30;
    for (int i = 0; i < 5000; i++) begin
      if (i % 500 == 0) rd_pct = $urandom_range(5, 90);
      rst = ($urandom_range(0, 599) == 0);
      clear = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) gpio_in = W'({$urandom(), $urandom()});
        else gpio_in = gpio_in ^ (W'(1) << $urandom_range(0, W - 1));
      end
      if ($urandom_range(0, 149) == 0) begin
        if ($urandom_range(0, 1) == 0) mask = '1;
        else mask = W'({$urandom(), $urandom()});
      end
      if ($urandom_range(0, 299) == 0) timeout_limit = TOW'($urandom_range(0, 12));
      rd_en = ($urandom_range(0, 99) < rd_pct);
      cyc();
    end
    rst = 0;
    clear = 0;
    rd_en = 0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gpio_event_monitor.md
Name: gpio_event_monitor

Overview:
- Synthesizable, parametrised monitor for a team GPIO output bus; lives in the team wrapper beside the design under test.
- Each masked change on the bus is captured with a cycle timestamp into an on-chip FIFO, which firmware or a debug port drains.
- An idle watchdog flags a design that has stopped toggling its outputs.
- Replaces bench-only print-on-change and timeout checking with hardware that also works on silicon.

Parameters:
- WIDTH, 34: monitored bus width.
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- TS_WIDTH, 16: timestamp counter width; the counter saturates.
- TO_WIDTH, 20: idle watchdog counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture enable.
- clear  in  1  synchronous soft clear.
- gpio_in  in  WIDTH  monitored bus; synchronous to clk.
- mask  in  WIDTH  per-bit change-detect enable.
- timeout_limit  in  TO_WIDTH  idle cycles before timeout; 0 disables the watchdog.
- rd_en  in  1  pop the head entry.
- rd_valid  out  1  head entry valid (equal to !empty).
- rd_data  out  WIDTH  bus value of the head entry.
- rd_ts  out  TS_WIDTH  timestamp of the head entry.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: an event was dropped.
- timeout  out  1  sticky: watchdog expired.

Behaviour:
- Reset (rst=1 at a clk edge), all cleared:
  - count=0, rd_valid=0, full=0, overflow=0, timeout=0.
  - rd_data=0, rd_ts=0.
  - prev=0, ts=0, idle=0, en_d=0.
- clear=1 has the same effect as rst except prev, which is loaded with gpio_in. rst has priority over clear.
- Enable edge: when en=1 and en_d=0:
  - prev <= gpio_in, ts <= 0, idle <= 0.
  - No event is generated on this cycle.
- Event: when en=1 and en_d=1 and ((gpio_in ^ prev) & mask) != 0:
  - Push {gpio_in, ts} at this edge.
  - prev <= gpio_in on every enabled cycle.
  - Unmasked bits still update prev but never cause an event.
- Timestamp: ts increments by 1 each enabled cycle after the enable edge, so the first post-enable cycle has ts=0. ts saturates at all-ones.
- Latency: gpio_in changes before edge k. The entry is stored at edge k, and rd_valid/rd_data/rd_ts reflect it after edge k (show-ahead head).
- Read:
  - rd_en=1 with rd_valid=1 pops at the edge.
  - rd_en with empty is ignored; it has no effect on count and no error flag.
- Full:
  - Push while full and no pop: event dropped, overflow <= 1, FIFO unchanged.
  - Push and pop on the same edge while full: both proceed, count stays DEPTH, no overflow.
- Empty: push and pop on the same edge while empty: the pop is ignored and the push is stored (count becomes 1).
- Pointers wrap modulo DEPTH. count is tracked separately so the full and empty cases are unambiguous.
- Watchdog:
  - While en=1 and timeout_limit!=0, idle increments each cycle with no event and resets to 0 on an event.
  - When idle reaches timeout_limit, timeout <= 1 (sticky) and idle holds.
  - Cleared only by rst or clear.
- en=0: no capture, ts and idle freeze, the FIFO stays readable, and pops still work.
  - Re-enable performs a fresh enable edge (ts restarts at 0).
- rst or clear mid-operation discards all FIFO contents and pending events on that edge.

Test Plan:
- Enable, mask=all ones, gpio_in 0 -> 0x5 at the 3rd enabled cycle, then 0x5 -> 0x4 at the 7th -> two entries: (0x5, ts=2) and (0x4, ts=6); count=2; rd_valid=1 after the first push edge.
- mask=0x1, toggle only bit 1 for 10 cycles, then toggle bit 0 -> exactly one entry holding the full bus value; bit-1 toggles not logged.
- DEPTH=16, 17 consecutive changes, no reads -> full=1, count=16, overflow=1, 17th event absent. Then simultaneous push+pop while full -> count stays 16, overflow unchanged.
- timeout_limit=100, one event then bus static -> timeout=1 exactly 100 cycles after the event edge. With timeout_limit=0, no timeout after 1000 idle cycles.
- 5 entries stored, assert clear on an edge where gpio_in also changes -> count=0, overflow=0, timeout=0, no entry logged. rd_en on the empty FIFO -> no change.
- Drop en for 20 cycles while toggling the bus, then re-enable and change the bus -> no entries during en=0; the next entry has ts=0 relative to re-enable; previously stored entries pop in order.
